// File: rtl/sprite_palette_bank.sv
// Multi-bank palette lookup: {bank, idx} -> 12-bit RGB with a two-stage pipeline,
// a runtime write port and a self-clearing INIT phase. Define PALETTE_FLASH_EN for the hit-flash effect.
module sprite_palette_bank #(
  parameter int IDX_W      = 4,
  parameter int NUM_BANKS  = 4,
  parameter int CH_W       = 4,
  parameter int TRANSP_IDX = 1,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              transparent,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_data,
  output logic              ready,
  input  logic              flash_start,
  input  logic [7:0]        flash_len,
  input  logic              frame_tick,
  output logic              flash_active
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int DEPTH   = NUM_BANKS * ENTRIES;
  localparam int ADDR_W  = BANK_W + IDX_W;
  localparam int DATA_W  = 3 * CH_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                s1_valid, s1_zero, s1_transp;
  logic [DATA_W-1:0]   s1_data;
  logic [DATA_W-1:0]   pix;
  logic                flash_on;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return 32'(b) < NUM_BANKS;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    mem_we      = 1'b0;
    mem_waddr   = {wr_bank, wr_idx};
    mem_wdata   = wr_data;
    case (state)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_ptr;
        mem_wdata   = '0;
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
      end
      ST_RUN:  mem_we = wr_en && bank_ok(wr_bank);
      default: state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign ready = (state == ST_RUN);

  // Stage 1: the synchronous read sees the pre-write contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_transp <= 1'b0;
      s1_data   <= '0;
    end else begin
      s1_valid  <= rd_valid;
      s1_zero   <= (state == ST_INIT) || !bank_ok(rd_bank);
      s1_transp <= !bank_ok(rd_bank) || (rd_idx == IDX_W'(TRANSP_IDX));
      s1_data   <= mem[{rd_bank, rd_idx}];
    end
  end

`ifdef PALETTE_FLASH_EN
  logic [7:0] flash_cnt;

  always_ff @(posedge clk) begin
    if (reset)                               flash_cnt <= '0;
    else if (flash_start)                    flash_cnt <= flash_len;
    else if (frame_tick && flash_cnt != '0)  flash_cnt <= flash_cnt - 8'd1;
  end

  assign flash_on     = (flash_cnt != '0) && flash_cnt[1];
  assign flash_active = (flash_cnt != '0);
`else
  logic unused_flash;
  assign unused_flash = ^{flash_start, flash_len, frame_tick};
  assign flash_on     = 1'b0;
  assign flash_active = 1'b0;
`endif

  always_comb begin
    pix = s1_data;
    if (s1_zero)                pix = '0;
    if (flash_on && !s1_transp) pix = '1;
    if (!s1_valid)              pix = '0;
  end

  // Stage 2: flash override applied, outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      transparent <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      out_valid   <= s1_valid;
      transparent <= s1_valid && s1_transp;
      red         <= pix[DATA_W-1 -: CH_W];
      green       <= pix[2*CH_W-1 -: CH_W];
      blue        <= pix[CH_W-1:0];
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Randomized and directed bench for sprite_palette_bank against a table-based reference model.
module tb_sprite_palette_bank;

  localparam int IDX_W     = 4;
  localparam int NUM_BANKS = 4;
  localparam int CH_W      = 4;
  localparam int BANK_W    = 2;
  localparam int ENTRIES   = 16;
`ifdef PALETTE_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_valid;
  logic [BANK_W-1:0] rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic [CH_W-1:0]   red, green, blue;
  logic              out_valid, transparent;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [11:0]       wr_data;
  logic              ready;
  logic              flash_start;
  logic [7:0]        flash_len;
  logic              frame_tick;
  logic              flash_active;

  always #5 clk = ~clk;

  sprite_palette_bank #(
    .IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS), .CH_W(CH_W), .TRANSP_IDX(1)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_idx(rd_idx),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .transparent(transparent),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_data(wr_data),
    .ready(ready),
    .flash_start(flash_start), .flash_len(flash_len), .frame_tick(frame_tick),
    .flash_active(flash_active)
  );

  typedef struct packed {
    logic        v;
    logic        tr;
    logic [11:0] col;
  } px_t;

  logic [11:0] m_mem [NUM_BANKS][ENTRIES];
  int          m_init_left;
  int          m_cnt;
  px_t         m_issued;   // lookup accepted at the previous edge
  px_t         m_out;      // what the outputs must show now
  bit          m_was_reset;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    px_t nxt_out, nxt_issued;
    bit  in_init, bank_ok;
    if (reset) begin
      foreach (m_mem[b, i]) m_mem[b][i] = 12'h000;
      m_init_left = NUM_BANKS * ENTRIES;
      m_cnt       = 0;
      m_issued    = '0;
      m_out       = '0;
      m_was_reset = 1'b1;
    end else begin
      m_was_reset = 1'b0;
      in_init = (m_init_left > 0);
      // Output stage: flash decision uses the counter as it stands before this edge.
      nxt_out.v   = m_issued.v;
      nxt_out.tr  = m_issued.tr;
      nxt_out.col = (FLASH_EN && (m_cnt % 4) >= 2 && !m_issued.tr) ? 12'hFFF : m_issued.col;
      // Lookup accepted this edge, against contents before this edge's write.
      bank_ok        = (int'(rd_bank) < NUM_BANKS);
      nxt_issued.v   = rd_valid;
      nxt_issued.tr  = !bank_ok || (rd_idx == 4'd1);
      nxt_issued.col = (!bank_ok || in_init) ? 12'h000 : m_mem[rd_bank][rd_idx];
      if (!in_init && wr_en && int'(wr_bank) < NUM_BANKS) m_mem[wr_bank][wr_idx] = wr_data;
      if (in_init) m_init_left--;
      if (FLASH_EN) begin
        if (flash_start)                  m_cnt = int'(flash_len);
        else if (frame_tick && m_cnt > 0) m_cnt--;
      end
      m_out    = nxt_out;
      m_issued = nxt_issued;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_out.v});
    if (m_out.v) begin
      check("transparent", {31'd0, transparent}, {31'd0, m_out.tr});
      check("colour", {20'd0, red, green, blue}, {20'd0, m_out.col});
    end
    if (m_was_reset) begin
      check("reset_colour", {20'd0, red, green, blue}, 32'd0);
      check("reset_transparent", {31'd0, transparent}, 32'd0);
    end
    check("ready", {31'd0, ready}, {31'd0, m_init_left == 0});
    check("flash_active", {31'd0, flash_active}, {31'd0, m_cnt != 0});
  endtask

  task automatic idle();
    rd_valid = 0; rd_bank = '0; rd_idx = '0;
    wr_en = 0; wr_bank = '0; wr_idx = '0; wr_data = '0;
    flash_start = 0; flash_len = '0; frame_tick = 0;
  endtask

  task automatic do_write(input int b, input int i, input logic [11:0] d);
    wr_en = 1; wr_bank = BANK_W'(b); wr_idx = IDX_W'(i); wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  task automatic do_read(input int b, input int i);
    rd_valid = 1; rd_bank = BANK_W'(b); rd_idx = IDX_W'(i);
    cycle();
    rd_valid = 0;
  endtask

  task automatic random_traffic(input int n, input bit with_flash);
    for (int k = 0; k < n; k++) begin
      rd_valid    = ($urandom_range(0, 3) != 0);
      rd_bank     = BANK_W'($urandom_range(0, NUM_BANKS - 1));
      rd_idx      = IDX_W'($urandom_range(0, ENTRIES - 1));
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_bank     = BANK_W'($urandom_range(0, NUM_BANKS - 1));
      wr_idx      = IDX_W'($urandom_range(0, ENTRIES - 1));
      wr_data     = 12'($urandom);
      flash_start = with_flash && ($urandom_range(0, 39) == 0);
      flash_len   = 8'($urandom_range(0, 15));
      frame_tick  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    m_init_left = 0; m_cnt = 0; m_issued = '0; m_out = '0; m_was_reset = 0;

    // Reset, then INIT sweep with lookups and ignored writes in flight.
    reset = 1;
    repeat (3) cycle();
    reset = 0;
    random_traffic(70, 1'b0);
    repeat (3) cycle();

    // Load (2,5) and read it back next cycle; (0,5) stays zero.
    do_write(2, 5, 12'hF20);
    do_read(2, 5);
    do_read(0, 5);
    repeat (2) cycle();

    // Back-to-back sweep of bank 1.
    for (int i = 0; i < ENTRIES; i++) do_write(1, i, 12'($urandom));
    for (int i = 0; i < ENTRIES; i++) begin
      rd_valid = 1; rd_bank = 2'd1; rd_idx = IDX_W'(i);
      cycle();
    end
    idle();
    repeat (2) cycle();

    // Same-cycle read and write of (0,3): old value first, new value next.
    do_write(0, 3, 12'h123);
    rd_valid = 1; rd_bank = 2'd0; rd_idx = 4'd3;
    wr_en = 1; wr_bank = 2'd0; wr_idx = 4'd3; wr_data = 12'hABC;
    cycle();
    idle();
    do_read(0, 3);
    repeat (2) cycle();

    // Flash of length 4 over a steady stream of opaque and transparent pixels.
    do_write(3, 7, 12'h123);
    do_write(3, 1, 12'h456);
    flash_start = 1; flash_len = 8'd4;
    cycle();
    flash_start = 0;
    for (int k = 0; k < 24; k++) begin
      rd_valid = 1; rd_bank = 2'd3; rd_idx = (k % 2 == 0) ? 4'd7 : 4'd1;
      frame_tick = (k % 4 == 3);
      cycle();
    end
    idle();
    flash_len = 8'd0; flash_start = 1;
    cycle();
    idle();
    repeat (3) cycle();

    // Mixed random traffic including flashes.
    random_traffic(600, 1'b1);
    repeat (3) cycle();

    // Reset in the middle of a flash with loaded data.
    flash_start = 1; flash_len = 8'd20;
    cycle();
    idle();
    do_read(3, 7);
    reset = 1;
    repeat (2) cycle();
    reset = 0;
    for (int k = 0; k < 70; k++) begin
      rd_valid = 1; rd_bank = 2'd3; rd_idx = IDX_W'(k % ENTRIES);
      cycle();
    end
    idle();
    do_read(3, 7);
    do_read(2, 5);
    do_read(0, 3);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Runtime-loadable, multi-bank colour lookup for the sprite pipeline. Sits between the sprite ROM index output and the VGA colour mux: maps a per-pixel palette index plus a bank select (one bank per character or costume) to 12-bit RGB. Adds a registered two-stage lookup, a write port for palette loading, a transparency flag and an optional hit-flash effect.

## Interface
- IDX_W, 4: index width; 2^IDX_W entries per bank
- NUM_BANKS, 4: number of palettes; bank select width BANK_W = max(1, $clog2(NUM_BANKS))
- CH_W, 4: bits per colour channel
- TRANSP_IDX, 1: index treated as transparent in every bank
- Clk  in  1  system clock; all logic rising-edge
- Reset  in  1  synchronous, active-high
- rd_valid  in  1  lookup request this cycle
- rd_bank  in  BANK_W  bank for lookup
- rd_idx  in  IDX_W  palette index for lookup
- red, green, blue  out  CH_W each  looked-up colour
- out_valid  out  1  colour outputs valid
- transparent  out  1  pixel index equals TRANSP_IDX
- wr_en  in  1  palette write strobe
- wr_bank  in  BANK_W  bank written
- wr_idx  in  IDX_W  entry written
- wr_data  in  3*CH_W  {red, green, blue}
- ready  out  1  initialisation done; writes accepted
- flash_start  in  1  begin hit-flash (pulse)
- flash_len  in  8  flash duration in frames
- frame_tick  in  1  one-cycle pulse per video frame
- flash_active  out  1  flash counter nonzero

## Operation
- State machine: INIT, RUN. Reset enters INIT with clear pointer 0.
- INIT: writes 0 to one entry per cycle, bank-major, index-minor; NUM_BANKS*2^IDX_W cycles; then RUN. ready=0 in INIT, 1 in RUN. wr_en in INIT ignored. Lookups in INIT still produce out_valid, colour 0.
- RUN: wr_en writes wr_data to entry (wr_bank, wr_idx) at the clock edge.
- wr_bank >= NUM_BANKS: write dropped. rd_bank >= NUM_BANKS: lookup returns 0, transparent=1.
- Read/write same entry same cycle: lookup returns the old value (read-before-write).
- transparent derived from rd_idx only, not stored colour.
- Flash (feature-gated): 8-bit counter. flash_start loads flash_len (restarts if already active); else frame_tick decrements when nonzero; flash_start wins over simultaneous frame_tick. While counter nonzero and counter[1]=1, non-transparent output pixels forced to all-ones per channel. flash_len=0 does nothing.
- Reset mid-operation: all contents, counter and pipeline cleared; INIT restarts.

## Timing
- Lookup latency 2 cycles: request at edge N, outputs valid after edge N+2. Fully pipelined, one lookup per cycle.
- Stage 1: register bank/idx/valid, memory read. Stage 2: apply flash override, register outputs.
- A write at edge N is visible to a lookup issued at edge N+1.
- Flash override uses the counter value at the stage-2 register edge.
- Reset values: red=green=blue=0, out_valid=0, transparent=0, ready=0, flash_active=0, counter=0.
- ready rises the cycle after the last INIT write.

## Configuration
- PALETTE_FLASH_EN defined: flash counter, override and flash_active present as above.
- Undefined: no counter logic; flash_start, flash_len, frame_tick ignored; flash_active tied 0; colour is plain lookup. Latency unchanged at 2.

## Test plan
- Reset, defaults: ready low exactly 64 cycles (4 banks x 16), then high; any lookup returns 000, out_valid 2 cycles after rd_valid.
- Load bank 2 index 5 = 12'hF20, lookup (2,5) next cycle -> red=F, green=2, blue=0 exactly 2 cycles later; bank 0 index 5 still 000.
- Back-to-back lookups idx 0..15 in bank 1, one per cycle -> 16 consecutive valid outputs in order; idx 1 sets transparent=1 only.
- Same-cycle write of 12'hABC and read on (0,3) previously 12'h123 -> read returns 123; following read returns ABC.
- Flash: flash_len=4, flash_start, lookup non-transparent 12'h123 with frame_ticks -> FFF while counter 3 or 2, 123 at counter 1 and 0; flash_active clears after 4th tick; transparent pixel never forced.
- Reset asserted mid-flash after loading data -> all outputs 0, ready low 64 cycles, previously loaded entries read 000.
